// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM states, reset vector, field widths and the
// opcode/funct encodings already used by the control unit.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNC_W  = 6;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0a;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0c;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

    localparam logic [FUNC_W-1:0] FN_SLL = 6'h00;
    localparam logic [FUNC_W-1:0] FN_SRL = 6'h02;
    localparam logic [FUNC_W-1:0] FN_JR  = 6'h08;
    localparam logic [FUNC_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNC_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNC_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNC_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNC_W-1:0] FN_SLT = 6'h2a;

    function automatic logic [OP_W-1:0] instr_op(input logic [INSTR_W-1:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [FUNC_W-1:0] instr_func(input logic [INSTR_W-1:0] instr);
        return instr[5:0];
    endfunction

endpackage

// File: rtl/pc_register.sv
// Fetch PC bookkeeping: sequential increment, redirect capture while a request is
// outstanding (pending_pc/drop_q), and redirect select once the memory answers.
module pc_register
    import mips_pkg::*;
#(
    parameter int unsigned         ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              is_req,
    input  logic              is_hold,
    input  logic              imem_ack_in,
    input  logic              redirect_in,
    input  logic [ADDR_W-1:0] target_in,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              drop_q,
    output logic              accept
);

    logic [ADDR_W-1:0] pending_pc;
    logic [ADDR_W-1:0] target_aligned;

    assign target_aligned = {target_in[ADDR_W-1:2], 2'b00};

    // The returning word is kept only if no redirect is pending or arriving now.
    assign accept = is_req && imem_ack_in && !drop_q && !redirect_in;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            fetch_pc   <= RESET_PC;
            pending_pc <= '0;
            drop_q     <= 1'b0;
        end else if (is_req) begin
            if (imem_ack_in) begin
                if (!drop_q && !redirect_in) begin
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                end else begin
                    fetch_pc <= redirect_in ? target_aligned : pending_pc;
                    drop_q   <= 1'b0;
                end
            end else if (redirect_in) begin
                // Address must stay stable until ack; remember the latest target.
                pending_pc <= target_aligned;
                drop_q     <= 1'b1;
            end
        end else if (is_hold && redirect_in) begin
            fetch_pc <= target_aligned;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding req/ack to instruction memory, holds the fetched
// instruction for decode and honours branch/jump redirects.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk_in,
    input  logic               reset_in,
    output logic               imem_req_out,
    output logic [ADDR_W-1:0]  imem_addr_out,
    input  logic               imem_ack_in,
    input  logic [INSTR_W-1:0] imem_rdata_in,
    input  logic               stall_in,
    input  logic               redirect_in,
    input  logic [ADDR_W-1:0]  target_in,
    output logic               valid_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic [OP_W-1:0]    op_out,
    output logic [FUNC_W-1:0]  func_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_plus4_out
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc;
    logic              drop_q;
    logic              accept;
    logic              release_hold;
    logic              is_req;
    logic              is_hold;

    assign is_req  = (state_q == REQ);
    assign is_hold = (state_q == HOLD);

    // Redirect leaves HOLD even when decode is stalled.
    assign release_hold = is_hold && (redirect_in || !stall_in);

    pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .is_req      (is_req),
        .is_hold     (is_hold),
        .imem_ack_in (imem_ack_in),
        .redirect_in (redirect_in),
        .target_in   (target_in),
        .fetch_pc    (fetch_pc),
        .drop_q      (drop_q),
        .accept      (accept)
    );

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        imem_req_out = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                imem_req_out = 1'b1;
                if (accept) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (release_hold) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_addr_out = fetch_pc;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            valid_out <= 1'b0;
            instr_out <= '0;
            pc_out    <= '0;
        end else if (accept) begin
            valid_out <= 1'b1;
            instr_out <= imem_rdata_in;
            pc_out    <= fetch_pc;
        end else if (release_hold) begin
            valid_out <= 1'b0;
        end
    end

    assign op_out       = instr_op(instr_out);
    assign func_out     = instr_func(instr_out);
    assign pc_plus4_out = pc_out + ADDR_W'(4);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational instruction memory model.
module tb_instr_fetch_unit;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_rdata_in;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] target_in;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [5:0]  op_out;
    logic [5:0]  func_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;

    int unsigned n_tests  = 0;
    int unsigned n_failed = 0;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .imem_req_out  (imem_req_out),
        .imem_addr_out (imem_addr_out),
        .imem_ack_in   (imem_ack_in),
        .imem_rdata_in (imem_rdata_in),
        .stall_in      (stall_in),
        .redirect_in   (redirect_in),
        .target_in     (target_in),
        .valid_out     (valid_out),
        .instr_out     (instr_out),
        .op_out        (op_out),
        .func_out      (func_out),
        .pc_out        (pc_out),
        .pc_plus4_out  (pc_plus4_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2008_0005 + (a << 4);
    endfunction

    assign imem_rdata_in = mem_word(imem_addr_out);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_req(input string tag, input logic [31:0] addr);
        check_eq({tag, "_req"}, {31'b0, imem_req_out}, 32'd1);
        check_eq({tag, "_addr"}, imem_addr_out, addr);
        check_eq({tag, "_valid"}, {31'b0, valid_out}, 32'd0);
    endtask

    task automatic check_hold(input string tag, input logic [31:0] pc);
        check_eq({tag, "_req"}, {31'b0, imem_req_out}, 32'd0);
        check_eq({tag, "_valid"}, {31'b0, valid_out}, 32'd1);
        check_eq({tag, "_pc"}, pc_out, pc);
        check_eq({tag, "_instr"}, instr_out, mem_word(pc));
        check_eq({tag, "_pc4"}, pc_plus4_out, pc + 32'd4);
    endtask

    initial begin
        reset_in    = 1'b1;
        imem_ack_in = 1'b1;
        stall_in    = 1'b0;
        redirect_in = 1'b0;
        target_in   = '0;
        step();
        step();
        check_eq("rst_req", {31'b0, imem_req_out}, 32'd0);
        check_eq("rst_valid", {31'b0, valid_out}, 32'd0);
        check_eq("rst_instr", instr_out, 32'd0);
        check_eq("rst_pc", pc_out, 32'd0);
        check_eq("rst_pc4", pc_plus4_out, 32'd4);
        reset_in = 1'b0;
        #1;
        check_eq("idle_req", {31'b0, imem_req_out}, 32'd0);

        // 1: zero-wait stream
        step(); check_req("t1_c1", 32'h0);
        step(); check_hold("t1_c2", 32'h0);
        check_eq("t1_op", {26'b0, op_out}, 32'h08);
        check_eq("t1_func", {26'b0, func_out}, 32'h05);
        step(); check_req("t1_c3", 32'h4);
        step(); check_hold("t1_c4", 32'h4);
        step(); check_req("t1_c5", 32'h8);
        step(); check_hold("t1_c6", 32'h8);
        step(); check_req("t1_c7", 32'hC);
        step(); check_hold("t1_c8", 32'hC);
        imem_ack_in = 1'b0;

        // 2: three wait states at 0x10
        for (int i = 0; i < 4; i++) begin
            step(); check_req("t2_wait", 32'h10);
        end
        imem_ack_in = 1'b1;
        step(); check_hold("t2_done", 32'h10);

        // 3: stall in HOLD
        stall_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(); check_hold("t3_stall", 32'h10);
        end
        stall_in = 1'b0;
        step(); check_req("t3_next", 32'h14);
        step(); check_hold("t3_hold", 32'h14);

        // 4: redirect to 0x8, then redirect to 0x40 while ack pending
        redirect_in = 1'b1; target_in = 32'h8; imem_ack_in = 1'b0;
        step(); check_req("t4_to8", 32'h8);
        target_in = 32'h40;
        step(); check_req("t4_pend1", 32'h8);
        redirect_in = 1'b0;
        step(); check_req("t4_pend2", 32'h8);
        imem_ack_in = 1'b1;
        step(); check_req("t4_drop", 32'h40);
        step(); check_hold("t4_hold", 32'h40);

        // 5: redirect beats stall, target low bits forced to zero
        stall_in = 1'b1; redirect_in = 1'b1; target_in = 32'h103;
        step(); check_req("t5_redir", 32'h100);
        stall_in = 1'b0; redirect_in = 1'b0;
        step(); check_hold("t5_hold", 32'h100);

        // wrap of pc_plus4 and fetch_pc
        redirect_in = 1'b1; target_in = 32'hFFFF_FFFF;
        step(); check_req("wrap_req", 32'hFFFF_FFFC);
        redirect_in = 1'b0;
        step(); check_hold("wrap_hold", 32'hFFFF_FFFC);
        step(); check_req("wrap_next", 32'h0);

        // 6: async reset with a pending redirect, late ack ignored
        imem_ack_in = 1'b0; redirect_in = 1'b1; target_in = 32'h80;
        step(); check_req("t6_pend", 32'h0);
        redirect_in = 1'b0;
        #2 reset_in = 1'b1;
        #1;
        check_eq("t6_rst_req", {31'b0, imem_req_out}, 32'd0);
        check_eq("t6_rst_valid", {31'b0, valid_out}, 32'd0);
        check_eq("t6_rst_pc", pc_out, 32'd0);
        check_eq("t6_rst_instr", instr_out, 32'd0);
        imem_ack_in = 1'b1;
        step();
        check_eq("t6_late_ack", {31'b0, imem_req_out}, 32'd0);
        reset_in = 1'b0;
        step(); check_req("t6_first", 32'h0);
        step(); check_hold("t6_hold", 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not end, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
